// File: rtl/phase_sample_reader.sv
// Single-clock reader for a divided-clock producer: a phase register with a rising strobe
// samples a wrapping counter into a small FIFO that drains over valid/ready.
module phase_sample_reader #(
  parameter int DIV   = 1,
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  parameter int OVF_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_l,
  input  logic                     en,
  input  logic                     out_ready,
  output logic                     sub_phase,
  output logic                     rise_stb,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     res,
  output logic [OVF_W-1:0]         ovf_cnt
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DIV_W-1:0] div_cnt;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             div_tc;
  logic             full;
  logic             pop;
  logic             push_ok;
  logic             drop;

  assign div_tc    = (div_cnt == DIV_W'(DIV - 1));
  assign rise_stb  = en & div_tc & ~sub_phase;
  assign full      = (level == LVL_W'(DEPTH));
  assign out_valid = (level != '0);
  assign pop       = out_valid & out_ready;
  // A full FIFO still accepts a sample when the head leaves on the same edge.
  assign push_ok   = rise_stb & (~full | pop);
  assign drop      = rise_stb & full & ~pop;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // Counter increments on the pre-edge phase, so a sample taken on the rising
  // edge always sees the value from before that edge.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      div_cnt   <= '0;
      sub_phase <= 1'b0;
      cnt       <= '0;
    end else if (en) begin
      if (div_tc) begin
        div_cnt   <= '0;
        sub_phase <= ~sub_phase;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (sub_phase) cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= cnt;
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      res     <= 1'b0;
      ovf_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // Flagged on the attempt, even when the sample itself is dropped.
      if (rise_stb && (cnt == '1)) res <= 1'b1;
      if (drop && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_phase_sample_reader.sv
// Bench for phase_sample_reader: DIV=1 and DIV=3 instances checked each cycle against
// a history-count reference model (enabled-cycle count, high-phase count, sample queue).
module tb_phase_sample_reader;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_l;
  logic       en;
  logic       rdy [2];
  logic       sp  [2];
  logic       rs  [2];
  logic       ov  [2];
  logic [1:0] od  [2];
  logic [2:0] lv  [2];
  logic       rr  [2];
  logic [7:0] oc  [2];

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  phase_sample_reader #(.DIV(1), .WIDTH(2), .DEPTH(DEPTH), .OVF_W(8)) u_a (
    .clk(clk), .reset_l(reset_l), .en(en), .out_ready(rdy[0]),
    .sub_phase(sp[0]), .rise_stb(rs[0]), .out_valid(ov[0]), .out_data(od[0]),
    .level(lv[0]), .res(rr[0]), .ovf_cnt(oc[0]));

  phase_sample_reader #(.DIV(3), .WIDTH(2), .DEPTH(DEPTH), .OVF_W(8)) u_b (
    .clk(clk), .reset_l(reset_l), .en(en), .out_ready(rdy[1]),
    .sub_phase(sp[1]), .rise_stb(rs[1]), .out_valid(ov[1]), .out_data(od[1]),
    .level(lv[1]), .res(rr[1]), .ovf_cnt(oc[1]));

  // Reference state: enabled cycles seen, enabled cycles spent in high phase.
  int unsigned m_n   [2];
  int unsigned m_inc [2];
  int unsigned m_ovf [2];
  bit          m_res [2];
  int          qa [$];
  int          qb [$];

  function automatic int unsigned div_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic bit m_phase(int k);
    return ((m_n[k] / div_of(k)) % 2) == 1;
  endfunction

  function automatic bit m_rise(int k, bit e);
    return e && (((m_n[k] + 1) % div_of(k)) == 0) && !m_phase(k);
  endfunction

  function automatic int qsize(int k);
    return (k == 0) ? qa.size() : qb.size();
  endfunction

  function automatic int qhead(int k);
    if (qsize(k) == 0) return 0;
    return (k == 0) ? qa[0] : qb[0];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_edge(int k, bit r, bit e, bit rd);
    bit rise, pop, was_full;
    int sample;
    if (!r) begin
      m_n[k] = 0; m_inc[k] = 0; m_ovf[k] = 0; m_res[k] = 0;
      if (k == 0) qa.delete(); else qb.delete();
      return;
    end
    rise     = m_rise(k, e);
    sample   = m_inc[k] % 4;
    was_full = (qsize(k) == DEPTH);
    pop      = (qsize(k) > 0) && rd;
    if (pop) begin
      if (k == 0) void'(qa.pop_front()); else void'(qb.pop_front());
    end
    if (rise) begin
      if (sample == 3) m_res[k] = 1;
      if (!was_full || pop) begin
        if (k == 0) qa.push_back(sample); else qb.push_back(sample);
      end else if (m_ovf[k] < 255) begin
        m_ovf[k]++;
      end
    end
    if (e) begin
      if (m_phase(k)) m_inc[k]++;
      m_n[k]++;
    end
  endtask

  task automatic step(bit r, bit e, bit ra, bit rb);
    @(negedge clk);
    reset_l = r; en = e; rdy[0] = ra; rdy[1] = rb;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rise_stb[%0d]", k), rs[k], m_rise(k, e));
      model_edge(k, r, e, rdy[k]);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("sub_phase[%0d]", k), sp[k], m_phase(k));
      chk($sformatf("out_valid[%0d]", k), ov[k], qsize(k) > 0);
      chk($sformatf("level[%0d]", k), lv[k], qsize(k));
      if (qsize(k) > 0) chk($sformatf("out_data[%0d]", k), od[k], qhead(k));
      chk($sformatf("res[%0d]", k), rr[k], m_res[k]);
      chk($sformatf("ovf_cnt[%0d]", k), oc[k], m_ovf[k]);
    end
  endtask

  initial begin
    reset_l = 1'b0; en = 1'b1; rdy[0] = 1'b1; rdy[1] = 1'b1;
    step(0, 1, 1, 1);
    step(0, 1, 1, 1);
    chk("reset_level", lv[0], 0);
    chk("reset_valid", ov[0], 0);

    // Free run: DIV=1 yields 0,1,2,3,0,1; DIV=3 yields 0,3 within 12 edges.
    repeat (12) step(1, 1, 1, 1);
    chk("run_res_a", rr[0], 1);
    chk("run_ovf_a", oc[0], 0);
    chk("run_res_b", rr[1], 1);

    // Back-pressure: four kept, four dropped, then drain in order.
    step(0, 1, 1, 1);
    repeat (16) step(1, 1, 0, 1);
    chk("bp_level", lv[0], 4);
    chk("bp_ovf", oc[0], 4);
    chk("bp_res", rr[0], 1);
    chk("bp_head", od[0], 0);
    repeat (6) step(1, 0, 1, 1);

    // Full FIFO, ready pulsed only on strobe cycles: pop and push both accepted.
    step(0, 1, 1, 1);
    repeat (8) step(1, 1, 0, 1);
    chk("full_level_pre", lv[0], 4);
    for (int i = 0; i < 6; i++) step(1, 1, m_rise(0, 1), 1);
    chk("full_level_post", lv[0], 4);
    chk("full_ovf_post", oc[0], 0);

    // Enable dropped for five cycles mid-run.
    step(0, 1, 1, 1);
    repeat (5) step(1, 1, 1, 1);
    repeat (5) step(1, 0, 0, 0);
    repeat (12) step(1, 1, 1, 1);

    // Reset with three entries held and res set.
    step(0, 1, 1, 1);
    for (int i = 0; i < 40 && !m_res[0]; i++) step(1, 1, 1, 1);
    for (int i = 0; i < 40 && qa.size() < 3; i++) step(1, 1, 0, 1);
    chk("prerst_level", lv[0], 3);
    chk("prerst_res", rr[0], 1);
    step(0, 1, 0, 1);
    chk("rst_level", lv[0], 0);
    chk("rst_res", rr[0], 0);
    chk("rst_phase", sp[0], 0);
    chk("rst_data", od[0], 0);
    step(1, 1, 0, 1);
    chk("post_rst_valid", ov[0], 1);
    chk("post_rst_data", od[0], 0);

    // Randomized traffic with occasional resets.
    repeat (400) begin
      step(($urandom % 60) != 0, ($urandom % 4) != 0, $urandom % 2, ($urandom % 3) != 0);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/phase_sample_reader.md
Name: phase_sample_reader

Overview:
- Race-free, single-clock reader for a divided-clock producer.
- The "slow domain" is a phase register plus a rising strobe, not a derived clock. A wrapping counter advances during the high phase.
- On each phase rising edge the counter is sampled and buffered in a small FIFO, which drains to the fast side over valid/ready.
- Ordering is fixed so the clock edge always beats the data update: every sample sees the pre-edge counter value. The block is used as the deterministic reference model for clock/non-clock race tests.

Parameters:
- DIV, 1, clk cycles per phase half-period (>=1). Phase toggles every DIV enabled cycles.
- WIDTH, 2, counter and sample width in bits.
- DEPTH, 4, FIFO entries (power of 2, >=2).
- OVF_W, 8, overflow counter width.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- reset_l  in  1  synchronous active-low reset, sampled on posedge clk.
- en  in  1  advance enable; when 0, divider, phase and counter are frozen.
- out_ready  in  1  downstream accepts the head entry.
- sub_phase  out  1  divided phase register.
- rise_stb  out  1  combinational; high in the cycle whose closing edge raises sub_phase.
- out_valid  out  1  FIFO non-empty.
- out_data  out  WIDTH  FIFO head entry.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- res  out  1  sticky: an all-ones sample has been captured.
- ovf_cnt  out  OVF_W  samples dropped while the FIFO was full; saturating.

Behaviour:
- Reset (reset_l=0 at posedge): div_cnt, sub_phase, cnt, FIFO pointers, level, res, ovf_cnt all go to 0. out_valid=0, out_data=0. Reset takes priority over every other event.
  - Reset asserted mid-operation discards FIFO contents. No partial state survives.
- Divider (only when en=1): div_cnt counts 0..DIV-1.
  - At div_cnt==DIV-1: sub_phase toggles and div_cnt returns to 0.
  - rise_stb = en & (div_cnt==DIV-1) & ~sub_phase.
- Counter: on a posedge with en=1 and pre-edge sub_phase==1, cnt <= cnt+1, wrapping mod 2^WIDTH.
  - The increment uses the pre-edge phase. A rising edge in the same cycle does not increment.
- Sample: on a posedge with rise_stb=1, the pre-edge value of cnt is pushed.
  - It is never the post-increment value. This is the clock-beats-data rule.
- res <= 1 on any push attempt whose sample is all-ones. It is set even if the push is dropped. It stays set until reset.
- FIFO behaviour:
  - A pop occurs when out_valid & out_ready.
  - A push is accepted if not full, or if full and a pop happens in the same cycle.
  - A push while full without a pop is dropped, and ovf_cnt increments, saturating at 2^OVF_W-1.
  - Simultaneous push and pop: level unchanged, ordering preserved.
  - Pop when empty: no effect.
  - Pointers wrap mod DEPTH.
- Latency: a pushed sample appears on out_data/out_valid one cycle after its push edge, when the FIFO was empty.
- out_data holds its value while out_valid=1 and out_ready=0. It is don't-care when out_valid=0; the bench checks it only when valid.
- DIV=1, en=1 from reset, out_ready=1:
  - sub_phase = 1,0,1,0... after edges 1,2,3,...
  - Samples 0,1,2,3,0,... are pushed at edges 1,3,5,7,9.
  - res rises after edge 7.

Test Plan:
- DIV=1, WIDTH=2, en=1, out_ready=1, 12 edges -> out_data sequence 0,1,2,3,0,1 (each valid one cycle after edges 1,3,5,7,9,11); res=1 from edge 7; ovf_cnt=0.
- DIV=3, en=1 -> sub_phase period 6 clk; rise_stb high in cycles closing edges 3,9,15; samples 0,3,6 mod 4 = 0,3,2; res set after edge 9.
- out_ready=0, DIV=1, DEPTH=4, 16 edges -> level saturates at 4 holding 0,1,2,3; 4 drops give ovf_cnt=4; res=1; releasing out_ready drains 0,1,2,3 in order.
- Full FIFO with out_ready=1 pulsed exactly on a rise_stb cycle -> pop and push both accepted; level stays 4; ovf_cnt unchanged.
- en dropped for 5 cycles mid-run -> sub_phase, cnt and level frozen, no rise_stb; resuming continues the exact sequence with no skipped or duplicated samples.
- reset_l=0 for 1 cycle with FIFO holding 3 entries and res=1 -> next cycle all outputs 0; the first post-reset sample is 0 at edge 1 after release.
